// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory port responder decoding a data RAM plus an MMIO window
// (status, TX byte FIFO, RX byte latch, free-running cycle timer); reads are registered, read-first.
module dmem_mmio_responder #(
    parameter int          RAM_DEPTH  = 4096,
    parameter logic [31:0] MMIO_BASE  = 32'h1000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid_in,
    input  logic [7:0]  rx_data_in
);
    localparam int RAW = $clog2(RAM_DEPTH);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;

    logic [31:0]    mem [RAM_DEPTH];
    logic [7:0]     fifo_q [FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d, rx_full_q, rx_full_d;
    logic [7:0]     rx_byte_q, rx_byte_d;
    logic [31:0]    timer_q, timer_d, q_q, q_d;
    logic           in_ram, is_status, is_tx, is_rx, is_timer;
    logic           tx_empty, tx_full, pop, push_req, push, rx_clr;

    always_comb begin
        in_ram    = address_dmem < 32'(RAM_DEPTH);
        is_status = address_dmem == MMIO_BASE;
        is_tx     = address_dmem == MMIO_BASE + 32'd1;
        is_rx     = address_dmem == MMIO_BASE + 32'd2;
        is_timer  = address_dmem == MMIO_BASE + 32'd3;
        tx_empty  = cnt_q == '0;
        tx_full   = cnt_q == CW'(FIFO_DEPTH);
        pop       = !tx_empty && tx_ready;
        push_req  = wren && is_tx;
        // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
        push      = push_req && (!tx_full || pop);
        rx_clr    = !wren && is_rx;
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        tx_ovr_d  = (push_req && tx_full && !pop) || (tx_ovr_q && !(wren && is_status && data[3]));
        rx_ovr_d  = (rx_valid_in && rx_full_q && !rx_clr) || (rx_ovr_q && !(wren && is_status && data[4]));
        rx_full_d = rx_valid_in || (rx_full_q && !rx_clr);
        rx_byte_d = rx_valid_in ? rx_data_in : rx_byte_q;
        timer_d   = (wren && is_timer) ? '0 : timer_q + 32'd1;
        q_d       = in_ram    ? mem[address_dmem[RAW-1:0]] :
                    is_status ? {27'b0, rx_ovr_q, tx_ovr_q, rx_full_q, tx_empty, tx_full} :
                    is_rx     ? {23'b0, rx_full_q, rx_byte_q} :
                    is_timer  ? timer_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tx_ovr_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            rx_full_q <= 1'b0;
            rx_byte_q <= '0;
            timer_q   <= '0;
            q_q       <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tx_ovr_q  <= tx_ovr_d;
            rx_ovr_q  <= rx_ovr_d;
            rx_full_q <= rx_full_d;
            rx_byte_q <= rx_byte_d;
            timer_q   <= timer_d;
            q_q       <= q_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) fifo_q[wr_ptr_q] <= data[7:0];
    end

    always_ff @(posedge clock) begin
        if (!reset && wren && in_ram) mem[address_dmem[RAW-1:0]] <= data;
    end

    assign q_dmem   = q_q;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? '0 : fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed bench with a queue-based behavioural model checked every cycle
// plus hand-computed literal expectations.
module tb_dmem_mmio_responder;
    localparam logic [31:0] B    = 32'h1000;
    localparam logic [31:0] IDLE = 32'h2000;

    logic        clock = 1'b0, reset = 1'b1, wren = 1'b0, tx_ready = 1'b0, rx_valid_in = 1'b0;
    logic [31:0] address_dmem = '0, data = '0;
    logic [7:0]  rx_data_in = '0;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [7:0]  tx_data;

    int n_chk = 0, n_fail = 0;

    dmem_mmio_responder dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory map and peripherals as plain arrays, a queue and flags.
    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo [$];
    bit          m_ok = 0, m_qk = 0, m_txo, m_rxo, m_rxf;
    logic [7:0]  m_rxb;
    logic [31:0] m_q, m_timer;

    always @(posedge clock) begin
        bit full, pop, preq, clr;
        if (reset) begin
            m_q = '0; m_qk = 1; m_fifo.delete(); m_rxf = 0; m_rxb = '0;
            m_txo = 0; m_rxo = 0; m_timer = '0; m_ok = 1;
        end else begin
            m_qk = 1;
            if (address_dmem < 32'd4096) begin
                m_qk = m_ram.exists(int'(address_dmem));
                m_q  = m_qk ? m_ram[int'(address_dmem)] : '0;
            end else if (address_dmem == B)
                m_q = {27'b0, m_rxo, m_txo, m_rxf, m_fifo.size() == 0, m_fifo.size() == 8};
            else if (address_dmem == B + 2) m_q = {23'b0, m_rxf, m_rxb};
            else if (address_dmem == B + 3) m_q = m_timer;
            else m_q = '0;
            full = m_fifo.size() == 8;
            pop  = m_fifo.size() > 0 && tx_ready;
            preq = wren && address_dmem == B + 1;
            clr  = !wren && address_dmem == B + 2;
            if (wren && address_dmem == B && data[3]) m_txo = 0;
            if (preq && full && !pop) m_txo = 1;
            if (pop) void'(m_fifo.pop_front());
            if (preq && (!full || pop)) m_fifo.push_back(data[7:0]);
            if (wren && address_dmem == B && data[4]) m_rxo = 0;
            if (rx_valid_in && m_rxf && !clr) m_rxo = 1;
            if (clr) m_rxf = 0;
            if (rx_valid_in) begin m_rxf = 1; m_rxb = rx_data_in; end
            m_timer = (wren && address_dmem == B + 3) ? '0 : m_timer + 32'd1;
            if (wren && address_dmem < 32'd4096) m_ram[int'(address_dmem)] = data;
        end
    end

    always @(negedge clock) begin
        if (m_ok) begin
            if (m_qk) check("model q_dmem", q_dmem, m_q);
            check("model tx_valid", {31'b0, tx_valid}, {31'b0, m_fifo.size() > 0});
            check("model tx_data", {24'b0, tx_data}, {24'b0, m_fifo.size() > 0 ? m_fifo[0] : 8'h00});
        end
    end

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a; data = d; wren = w;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] exp4 [8];
        cyc(IDLE, 0, 0);
        cyc(IDLE, 0, 0);
        reset = 0;
        cyc(B, 0, 0);                 check("reset status", q_dmem, 32'h2);
        check("reset tx_valid", {31'b0, tx_valid}, 32'h0);
        // RAM
        cyc(5, 32'hDEADBEEF, 1);
        cyc(6, 32'h12345678, 1);
        cyc(5, 0, 0);                 check("ram @5", q_dmem, 32'hDEADBEEF);
        cyc(6, 32'hCAFEF00D, 1);      check("ram @6 read-first", q_dmem, 32'h12345678);
        cyc(6, 0, 0);                 check("ram @6", q_dmem, 32'hCAFEF00D);
        cyc(B + 1, 0, 0);             check("txdata read", q_dmem, 32'h0);
        // TX FIFO fill, overflow, drain
        for (int i = 1; i <= 8; i++) cyc(B + 1, i, 1);
        cyc(B, 0, 0);                 check("tx full status", q_dmem, 32'h1);
        cyc(B + 1, 9, 1);
        cyc(B, 0, 0);                 check("tx ovr status", q_dmem, 32'h9);
        tx_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            check("drain valid", {31'b0, tx_valid}, 32'h1);
            check("drain byte", {24'b0, tx_data}, i);
            cyc(IDLE, 0, 0);
        end
        check("drained valid", {31'b0, tx_valid}, 32'h0);
        cyc(B, 8, 1);
        cyc(B, 0, 0);                 check("tx ovr cleared", q_dmem, 32'h2);
        // Full FIFO with simultaneous push and pop
        tx_ready = 0;
        for (int i = 0; i < 8; i++) cyc(B + 1, 32'h11 + i, 1);
        tx_ready = 1;
        check("simul head", {24'b0, tx_data}, 32'h11);
        cyc(B + 1, 32'hAA, 1);
        exp4 = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            check("simul order", {24'b0, tx_data}, {24'b0, exp4[i]});
            cyc(IDLE, 0, 0);
        end
        cyc(B, 0, 0);                 check("simul no ovr", q_dmem, 32'h2);
        // RX latch
        rx_valid_in = 1; rx_data_in = 8'h5A;
        cyc(IDLE, 0, 0);
        rx_valid_in = 0;
        cyc(B + 2, 0, 0);             check("rx first read", q_dmem, 32'h15A);
        cyc(B + 2, 0, 0);             check("rx second read", q_dmem, 32'h05A);
        rx_valid_in = 1; rx_data_in = 8'h11;
        cyc(IDLE, 0, 0);
        rx_data_in = 8'h22;
        cyc(IDLE, 0, 0);
        rx_valid_in = 0;
        cyc(B, 0, 0);                 check("rx ovr status", q_dmem, 32'h16);
        cyc(B, 32'h10, 1);            check("status write read-first", q_dmem, 32'h16);
        cyc(B, 0, 0);                 check("rx ovr cleared", q_dmem, 32'h06);
        rx_valid_in = 1; rx_data_in = 8'h33;
        cyc(B + 2, 0, 0);             check("rx read+strobe", q_dmem, 32'h122);
        rx_valid_in = 0;
        cyc(B, 0, 0);                 check("rx no ovr on clear edge", q_dmem, 32'h06);
        cyc(B + 2, 0, 0);             check("rx new byte", q_dmem, 32'h133);
        // TIMER
        cyc(B + 3, 32'h55, 1);
        cyc(IDLE, 0, 0);
        cyc(IDLE, 0, 0);
        cyc(IDLE, 0, 0);
        cyc(B + 3, 0, 0);             check("timer after write", q_dmem, 32'h3);
        force dut.timer_q = 32'hFFFF_FFFF;
        m_timer = 32'hFFFF_FFFF;
        #1;
        release dut.timer_q;
        cyc(B + 3, 0, 0);             check("timer max", q_dmem, 32'hFFFF_FFFF);
        cyc(B + 3, 0, 0);             check("timer wrap", q_dmem, 32'h0);
        // Reset mid-operation
        tx_ready = 0;
        for (int i = 0; i < 3; i++) cyc(B + 1, 32'h60 + i, 1);
        rx_valid_in = 1; rx_data_in = 8'h44;
        cyc(IDLE, 0, 0);
        reset = 1; rx_data_in = 8'h77; tx_ready = 1;
        cyc(5, 0, 1);
        reset = 0; rx_valid_in = 0; tx_ready = 0;
        check("post-reset tx_valid", {31'b0, tx_valid}, 32'h0);
        check("post-reset tx_data", {24'b0, tx_data}, 32'h0);
        check("post-reset q_dmem", q_dmem, 32'h0);
        cyc(B, 0, 0);                 check("post-reset status", q_dmem, 32'h2);
        cyc(5, 0, 0);                 check("ram kept over reset", q_dmem, 32'hDEADBEEF);
        cyc(B + 2, 0, 0);             check("post-reset rxdata", q_dmem, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
